mem_arbiter: RTL and testbench

Shares the single memory port between the instruction fetch stage (read-only) and the load/store path (read/write). Data accesses have fixed priority; a wait counter guarantees the fetch port is served within a bounded number of grants. A flush input discards an in-flight fetch without stalling the memory protocol. All outputs are registered.

---
 rtl/limb_defs.sv | 23 ++
 rtl/arb_wait_counter.sv | 43 ++++
 rtl/mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/limb_defs.sv
`default_nettype none
// ============================================================================
// Package : limb_defs
// Purpose : Definitions shared by the memory arbiter and its helpers.
//           - arb_state_t : arbiter FSM state encoding (2 bits)
//           - arb_port_t  : identifies the requesting port (fetch or data)
// Rev     : 1.0  initial release
// ============================================================================
package limb_defs;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

endpackage : limb_defs
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module  : arb_wait_counter
// Purpose : Saturating up-counter. Counts how many data grants in a row the
//           fetch port has lost. o_sat tells the arbiter to favour fetch.
// Ports   : clk, rst  - clock, asynchronous active-high reset
//           i_inc     - count up by one (ignored once saturated)
//           i_clr     - clear to zero (takes priority over i_inc)
//           o_cnt     - current count, $clog2(MAX+1) bits
//           o_sat     - high when o_cnt == MAX
// Rev     : 1.0  initial release
// ============================================================================
module arb_wait_counter #(
  parameter int MAX   = 4,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = (r_cnt == C_MAX);

endmodule : arb_wait_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Shares one memory port between instruction fetch (read-only) and
//           the load/store path. Data has fixed priority; a wait counter
//           forces a fetch grant after MAX_WAIT lost decisions. flush_i
//           drops an in-flight fetch result without aborting the memory
//           transaction. All outputs are registered.
// Ports   : clk, rst                      - clock, async active-high reset
//           i_req_i/i_addr_i              - fetch request and address
//           flush_i                       - cancel current/pending fetch
//           i_ack_o/i_rdata_o             - fetch completion pulse + data
//           d_req_i/d_addr_i/d_we_i/
//           d_be_i/d_wdata_i              - data request and attributes
//           d_ack_o/d_rdata_o             - data completion pulse + data
//           mem_req_o/mem_addr_o/mem_we_o/
//           mem_be_o/mem_wdata_o          - memory request (held to ack)
//           mem_ack_i/mem_rdata_i         - memory completion + read data
// Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter
  import limb_defs::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  input  logic                flush_i,
  output logic                i_ack_o,
  output logic [DATA_W-1:0]   i_rdata_o,
  // data port
  input  logic                d_req_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_ack_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  // memory port
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  arb_port_t        w_win_port;
  logic             w_grant;
  logic             w_done;
  logic             w_fetch_ok;
  logic             w_i_elig;
  logic             w_d_elig;
  logic             w_cnt_inc;
  logic             w_cnt_clr;
  logic             w_sat;
  logic [CNT_W-1:0] w_wait_cnt;
  logic             r_drop;

  // A request is not eligible in the cycle its ack pulse is showing: the
  // requester has not yet had a chance to drop it, so a held request only
  // counts as new from the following cycle.
  assign w_i_elig = i_req_i && !flush_i && !i_ack_o;
  assign w_d_elig = d_req_i && !d_ack_o;

  arb_wait_counter #(
    .MAX   (MAX_WAIT),
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_cnt_inc),
    .i_clr (w_cnt_clr),
    .o_cnt (w_wait_cnt),
    .o_sat (w_sat)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state, grant decision, completion
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_win_port  = PORT_D;
    w_done      = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        // Data wins unless fetch has lost MAX_WAIT decisions in a row.
        if (w_d_elig && !(w_sat && w_i_elig)) begin
          w_grant     = 1'b1;
          w_win_port  = PORT_D;
          w_state_nxt = ARB_BUSY_D;
          w_cnt_inc   = w_i_elig;
        end else if (w_i_elig) begin
          w_grant     = 1'b1;
          w_win_port  = PORT_I;
          w_state_nxt = ARB_BUSY_I;
          w_cnt_clr   = 1'b1;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem_ack_i) begin
          w_done      = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // A flush arriving on the completing edge still suppresses the result.
  assign w_fetch_ok = (r_state == ARB_BUSY_I) && !r_drop && !flush_i;

  // --------------------------------------------------------------------------
  // Drop flag: remembers that the in-flight fetch was flushed. A flush on a
  // would-be fetch granting edge makes the fetch ineligible, so only flushes
  // seen in BUSY_I need recording.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= 1'b0;
    end else if (w_done) begin
      r_drop <= 1'b0;
    end else if ((r_state == ARB_BUSY_I) && flush_i) begin
      r_drop <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs: memory request latching and ack generation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      i_ack_o     <= 1'b0;
      i_rdata_o   <= '0;
      d_ack_o     <= 1'b0;
      d_rdata_o   <= '0;
    end else begin
      i_ack_o <= 1'b0;
      d_ack_o <= 1'b0;

      if (w_grant) begin
        mem_req_o <= 1'b1;
        if (w_win_port == PORT_D) begin
          mem_addr_o  <= d_addr_i;
          mem_we_o    <= d_we_i;
          mem_be_o    <= d_be_i;
          mem_wdata_o <= d_wdata_i;
        end else begin
          mem_addr_o  <= i_addr_i;
          mem_we_o    <= 1'b0;
          mem_be_o    <= '1;
          mem_wdata_o <= '0;
        end
      end

      if (w_done) begin
        mem_req_o <= 1'b0;
        if (r_state == ARB_BUSY_D) begin
          d_rdata_o <= mem_rdata_i;
          d_ack_o   <= 1'b1;
        end else if (w_fetch_ok) begin
          i_rdata_o <= mem_rdata_i;
          i_ack_o   <= 1'b1;
        end
      end
    end
  end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Directed self-checking bench for mem_arbiter. The bench plays
//           both requesters and the memory; inputs change 1 ns after each
//           rising edge and outputs are sampled there too.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic                clk;
  logic                rst;
  logic                i_req_i;
  logic [ADDR_W-1:0]   i_addr_i;
  logic                flush_i;
  logic                i_ack_o;
  logic [DATA_W-1:0]   i_rdata_o;
  logic                d_req_i;
  logic [ADDR_W-1:0]   d_addr_i;
  logic                d_we_i;
  logic [DATA_W/8-1:0] d_be_i;
  logic [DATA_W-1:0]   d_wdata_i;
  logic                d_ack_o;
  logic [DATA_W-1:0]   d_rdata_o;
  logic                mem_req_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic                mem_we_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic                mem_ack_i;
  logic [DATA_W-1:0]   mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_i     (i_req_i),
    .i_addr_i    (i_addr_i),
    .flush_i     (flush_i),
    .i_ack_o     (i_ack_o),
    .i_rdata_o   (i_rdata_o),
    .d_req_i     (d_req_i),
    .d_addr_i    (d_addr_i),
    .d_we_i      (d_we_i),
    .d_be_i      (d_be_i),
    .d_wdata_i   (d_wdata_i),
    .d_ack_o     (d_ack_o),
    .d_rdata_o   (d_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    i_req_i     = 1'b0;
    i_addr_i    = '0;
    flush_i     = 1'b0;
    d_req_i     = 1'b0;
    d_addr_i    = '0;
    d_we_i      = 1'b0;
    d_be_i      = '0;
    d_wdata_i   = '0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;

    // ---------------- reset state ----------------
    #12;
    chk("rst_mem_req",   64'(mem_req_o),   64'h0);
    chk("rst_mem_addr",  64'(mem_addr_o),  64'h0);
    chk("rst_mem_we",    64'(mem_we_o),    64'h0);
    chk("rst_mem_be",    64'(mem_be_o),    64'h0);
    chk("rst_mem_wdata", 64'(mem_wdata_o), 64'h0);
    chk("rst_i_ack",     64'(i_ack_o),     64'h0);
    chk("rst_i_rdata",   64'(i_rdata_o),   64'h0);
    chk("rst_d_ack",     64'(d_ack_o),     64'h0);
    chk("rst_d_rdata",   64'(d_rdata_o),   64'h0);
    chk("rst_state",     64'(u_dut.r_state),    64'h0);
    chk("rst_wait_cnt",  64'(u_dut.w_wait_cnt), 64'h0);
    rst = 1'b0;
    tick();

    // ---------------- stray memory ack in IDLE is ignored ----------------
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h9999_9999;
    tick();
    chk("idle_ack_i_ack",   64'(i_ack_o),   64'h0);
    chk("idle_ack_d_ack",   64'(d_ack_o),   64'h0);
    chk("idle_ack_d_rdata", 64'(d_rdata_o), 64'h0);
    chk("idle_ack_mem_req", 64'(mem_req_o), 64'h0);
    mem_ack_i = 1'b0;
    tick();

    // ---------------- single fetch ----------------
    i_req_i  = 1'b1;
    i_addr_i = 32'h100;
    tick();  // edge 0: grant
    chk("fetch_mem_req",  64'(mem_req_o),  64'h1);
    chk("fetch_mem_addr", 64'(mem_addr_o), 64'h100);
    chk("fetch_mem_we",   64'(mem_we_o),   64'h0);
    chk("fetch_mem_be",   64'(mem_be_o),   64'hF);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hE3A0_0001;
    tick();  // edge 1: complete
    chk("fetch_i_ack",   64'(i_ack_o),   64'h1);
    chk("fetch_i_rdata", 64'(i_rdata_o), 64'hE3A0_0001);
    chk("fetch_mem_req_drop", 64'(mem_req_o), 64'h0);
    i_req_i   = 1'b0;
    mem_ack_i = 1'b0;
    tick();
    chk("fetch_i_ack_pulse", 64'(i_ack_o), 64'h0);

    // ---------------- simultaneous requests ----------------
    i_req_i  = 1'b1;
    i_addr_i = 32'h104;
    d_req_i  = 1'b1;
    d_addr_i = 32'h300;
    d_we_i   = 1'b0;
    d_be_i   = 4'hF;
    tick();  // edge 0: data wins
    chk("sim_mem_addr_d", 64'(mem_addr_o), 64'h300);
    chk("sim_wait_cnt1",  64'(u_dut.w_wait_cnt), 64'h1);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h1111_1111;
    tick();  // edge 1: data completes
    chk("sim_d_ack",   64'(d_ack_o),   64'h1);
    chk("sim_d_rdata", 64'(d_rdata_o), 64'h1111_1111);
    chk("sim_i_ack0",  64'(i_ack_o),   64'h0);
    d_req_i     = 1'b0;
    mem_rdata_i = 32'h2222_2222;
    tick();  // fetch granted; ack held high is ignored while idle
    chk("sim_mem_addr_i", 64'(mem_addr_o), 64'h104);
    chk("sim_mem_req_i",  64'(mem_req_o),  64'h1);
    chk("sim_wait_cnt0",  64'(u_dut.w_wait_cnt), 64'h0);
    tick();  // fetch completes
    chk("sim_i_ack",   64'(i_ack_o),   64'h1);
    chk("sim_i_rdata", 64'(i_rdata_o), 64'h2222_2222);
    chk("sim_d_ack0",  64'(d_ack_o),   64'h0);
    i_req_i   = 1'b0;
    mem_ack_i = 1'b0;
    tick();

    // ---------------- starvation ----------------
    // flush_i is pulsed during each d_ack cycle so the fetch cannot take the
    // slot in which the held data request is ineligible.
    i_req_i  = 1'b1;
    i_addr_i = 32'h108;
    d_req_i  = 1'b1;
    d_addr_i = 32'h600;
    for (int k = 0; k < MAX_WAIT; k++) begin
      tick();  // data grant
      chk("starve_mem_addr_d", 64'(mem_addr_o), 64'h600);
      chk("starve_wait_cnt",   64'(u_dut.w_wait_cnt), 64'(k + 1));
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h3333_0000 + 32'(k);
      tick();  // data completes
      chk("starve_d_ack", 64'(d_ack_o), 64'h1);
      mem_ack_i = 1'b0;
      flush_i   = 1'b1;
      tick();  // nothing eligible
      chk("starve_gap_mem_req", 64'(mem_req_o), 64'h0);
      flush_i = 1'b0;
    end
    tick();  // 5th decision: fetch forced
    chk("starve_mem_addr_i", 64'(mem_addr_o), 64'h108);
    chk("starve_mem_we_i",   64'(mem_we_o),   64'h0);
    chk("starve_wait_clr",   64'(u_dut.w_wait_cnt), 64'h0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hCAFE_0005;
    tick();
    chk("starve_i_ack",   64'(i_ack_o),   64'h1);
    chk("starve_i_rdata", 64'(i_rdata_o), 64'hCAFE_0005);
    i_req_i   = 1'b0;
    d_req_i   = 1'b0;
    mem_ack_i = 1'b0;
    tick();

    // ---------------- flush in flight ----------------
    i_req_i  = 1'b1;
    i_addr_i = 32'h10C;
    tick();  // edge 0: fetch grant
    chk("flush_mem_addr", 64'(mem_addr_o), 64'h10C);
    tick();  // cycle 2
    flush_i  = 1'b1;
    i_req_i  = 1'b0;
    d_req_i  = 1'b1;
    d_addr_i = 32'h400;
    tick();  // cycle 3
    flush_i = 1'b0;
    tick();  // cycle 4
    chk("flush_busy_mem_req",  64'(mem_req_o),  64'h1);
    chk("flush_busy_mem_addr", 64'(mem_addr_o), 64'h10C);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0_BAD0;
    tick();  // cycle 5: dropped completion
    chk("flush_i_ack",   64'(i_ack_o),   64'h0);
    chk("flush_i_rdata", 64'(i_rdata_o), 64'hCAFE_0005);
    chk("flush_mem_req", 64'(mem_req_o), 64'h0);
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h4444_4444;
    tick();  // cycle 6: data granted at edge 5
    chk("flush_d_grant_req",  64'(mem_req_o),  64'h1);
    chk("flush_d_grant_addr", 64'(mem_addr_o), 64'h400);
    mem_ack_i = 1'b1;
    tick();
    chk("flush_d_ack",   64'(d_ack_o),   64'h1);
    chk("flush_d_rdata", 64'(d_rdata_o), 64'h4444_4444);
    chk("flush_i_ack2",  64'(i_ack_o),   64'h0);
    d_req_i   = 1'b0;
    mem_ack_i = 1'b0;
    tick();

    // ---------------- store ----------------
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_be_i    = 4'b0011;
    d_wdata_i = 32'hDEAD_BEEF;
    d_addr_i  = 32'h2000;
    tick();
    chk("store_mem_req",   64'(mem_req_o),   64'h1);
    chk("store_mem_addr",  64'(mem_addr_o),  64'h2000);
    chk("store_mem_we",    64'(mem_we_o),    64'h1);
    chk("store_mem_be",    64'(mem_be_o),    64'h3);
    chk("store_mem_wdata", 64'(mem_wdata_o), 64'hDEAD_BEEF);
    tick();  // memory stalls one cycle
    chk("store_wait_d_ack",   64'(d_ack_o),   64'h0);
    chk("store_wait_mem_req", 64'(mem_req_o), 64'h1);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h5555_5555;
    tick();
    chk("store_d_ack",      64'(d_ack_o),     64'h1);
    chk("store_mem_req0",   64'(mem_req_o),   64'h0);
    chk("store_addr_hold",  64'(mem_addr_o),  64'h2000);
    chk("store_wdata_hold", 64'(mem_wdata_o), 64'hDEAD_BEEF);
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
    mem_ack_i = 1'b0;
    tick();

    // ---------------- reset in BUSY_D ----------------
    d_req_i  = 1'b1;
    d_addr_i = 32'h500;
    d_be_i   = 4'hF;
    tick();
    chk("rbusy_state",   64'(u_dut.r_state), 64'h2);
    chk("rbusy_mem_req", 64'(mem_req_o),     64'h1);
    #3;
    rst = 1'b1;
    #1;  // between clock edges
    chk("arst_mem_req",   64'(mem_req_o),   64'h0);
    chk("arst_mem_addr",  64'(mem_addr_o),  64'h0);
    chk("arst_mem_we",    64'(mem_we_o),    64'h0);
    chk("arst_mem_be",    64'(mem_be_o),    64'h0);
    chk("arst_mem_wdata", 64'(mem_wdata_o), 64'h0);
    chk("arst_d_ack",     64'(d_ack_o),     64'h0);
    chk("arst_d_rdata",   64'(d_rdata_o),   64'h0);
    chk("arst_i_rdata",   64'(i_rdata_o),   64'h0);
    d_req_i = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    chk("arst_state_after", 64'(u_dut.r_state), 64'h0);
    chk("arst_mem_req_after", 64'(mem_req_o),   64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
